chiselwatt_clk_ctrl: RTL and testbench

Parametrised clock-control block that follows the PLL. It qualifies the PLL `lock` signal and sequences staggered per-domain reset release. It generates NUM_CH runtime-programmable clock-enable strobes in the single PLL output clock domain. It sits between the PLL wrapper and the core, memory and UART reset/enable inputs, replacing ad-hoc `lock`-driven resets.

---
 rtl/chiselwatt_clk_pkg.sv | 16 +
 rtl/chiselwatt_clk_ctrl_if.sv | 15 +
 rtl/chiselwatt_ce_div.sv | 35 +++
 rtl/chiselwatt_clk_ctrl.sv | 138 +++++++++++++
 tb/tb_chiselwatt_clk_ctrl.sv | 133 +++++++++++++
 5 files changed

// File: rtl/chiselwatt_clk_pkg.sv
// Shared types and width helpers for the PLL-following clock-control block.
package chiselwatt_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Counter width for a count range of x values, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
  endfunction

endpackage

// File: rtl/chiselwatt_clk_ctrl_if.sv
// Lock/divide inputs and reset/enable outputs of the clock-control block.
interface chiselwatt_clk_ctrl_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIV_W  = 8
);
  logic                      lock;
  logic [NUM_CH*DIV_W-1:0]   div;
  logic [NUM_CH-1:0]         rst_out_n;
  logic [NUM_CH-1:0]         ce;
  logic                      ready;

  // master: the clock controller; slave: PLL wrapper and reset/enable consumers
  modport master (input lock, div, output rst_out_n, ce, ready);
  modport slave  (output lock, div, input rst_out_n, ce, ready);
endinterface

// File: rtl/chiselwatt_ce_div.sv
// Per-channel clock-enable divider: one-cycle strobe every d_act+1 cycles while enabled.
module chiselwatt_ce_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] d,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] d_act_q;

  // Divide value is only taken while idle or at wrap so a period is never cut short
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      d_act_q <= '0;
      ce      <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      d_act_q <= d;
      ce      <= 1'b0;
    end else if (cnt_q == d_act_q) begin
      cnt_q   <= '0;
      d_act_q <= d;
      ce      <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
      ce      <= 1'b0;
    end
  end

endmodule

// File: rtl/chiselwatt_clk_ctrl.sv
// PLL lock qualification, staggered per-channel reset release and clock-enable strobes.
module chiselwatt_clk_ctrl
  import chiselwatt_clk_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned STAGGER     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  chiselwatt_clk_ctrl_if.master io
);

  localparam int unsigned STAB_W = clog2_min1(LOCK_CYCLES);
  localparam int unsigned STAG_W = clog2_min1(STAGGER);
  localparam int unsigned IDX_W  = clog2_min1(NUM_CH);

  logic [1:0]        sync_q;
  logic              lock_s;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [STAG_W-1:0] stag_q, stag_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;
  logic [NUM_CH-1:0] div_en;
  logic [NUM_CH-1:0] ce_w;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], io.lock};
  end
  assign lock_s = sync_q[1];

  // State, counters and registered reset/ready outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      stag_q  <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      stag_q  <= stag_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign idx_inc = idx_q + IDX_W'(1);

  // Next state; a drop of lock_s wins over every other transition
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    stag_d  = stag_q;
    idx_d   = idx_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stab_q == STAB_W'(LOCK_CYCLES - 1)) begin
          state_d = (NUM_CH == 1) ? RUN : RELEASE;
          idx_d   = '0;
          stag_d  = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stag_q == STAG_W'(STAGGER - 1)) begin
          stag_d = '0;
          idx_d  = idx_inc;
          if (idx_inc == IDX_W'(NUM_CH - 1)) state_d = RUN;
        end else begin
          stag_d = stag_q + STAG_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (state_d == WAIT_LOCK || state_d == STABLE && state_q == WAIT_LOCK) begin
      stab_d = '0;
      stag_d = '0;
      idx_d  = '0;
    end
  end

  // Output values for the coming edge, derived from the next state
  always_comb begin
    rst_d   = rst_q;
    ready_d = 1'b0;
    case (state_d)
      RELEASE: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (idx_d == IDX_W'(k)) rst_d[k] = 1'b1;
        end
      end
      RUN: begin
        rst_d   = '1;
        ready_d = 1'b1;
      end
      default: rst_d = '0;
    endcase
  end

  // Divider runs only while the channel is out of reset now and on the next edge,
  // so strobes stop on the same edge that a lock loss clears the resets
  assign div_en = rst_q & rst_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chiselwatt_ce_div #(.DIV_W(DIV_W)) u_div (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (div_en[k]),
      .d       (io.div[k*DIV_W +: DIV_W]),
      .ce      (ce_w[k])
    );
  end

  assign io.rst_out_n = rst_q;
  assign io.ready     = ready_q;
  assign io.ce        = ce_w;

endmodule

// File: tb/tb_chiselwatt_clk_ctrl.sv
// Directed bench: default 3-channel instance plus a 1-channel/1-cycle instance on shared lock/reset.
module tb_chiselwatt_clk_ctrl;

  logic clock;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  chiselwatt_clk_ctrl_if #(.NUM_CH(3), .DIV_W(8)) bus_a ();
  chiselwatt_clk_ctrl_if #(.NUM_CH(1), .DIV_W(8)) bus_b ();

  chiselwatt_clk_ctrl #(
    .NUM_CH(3), .DIV_W(8), .LOCK_CYCLES(16), .STAGGER(4)
  ) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus_a)
  );

  chiselwatt_clk_ctrl #(
    .NUM_CH(1), .DIV_W(8), .LOCK_CYCLES(1), .STAGGER(1)
  ) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus_b)
  );

  assign bus_b.lock = bus_a.lock;
  assign bus_b.div  = 8'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Release reset just before an edge so that edge becomes cycle 1
  task automatic restart();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset_n    = 1'b0;
    bus_a.lock = 1'b1;
    bus_a.div  = {8'hFF, 8'd3, 8'd2};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_reset", 32'(bus_a.rst_out_n), 32'd0);
    chk("ce_a_reset",  32'(bus_a.ce),        32'd0);
    chk("rdy_a_reset", 32'(bus_a.ready),     32'd0);
    chk("rst_b_reset", 32'(bus_b.rst_out_n), 32'd0);

    // Lock held from the start; div[1] drops 3 -> 0 after edge 32
    restart();
    for (int n = 1; n <= 1060; n++) begin
      step();
      chk("rst_a",  32'(bus_a.rst_out_n), 32'({n >= 27, n >= 23, n >= 19}));
      chk("rdy_a",  32'(bus_a.ready),     32'(n >= 27));
      chk("ce0",    32'(bus_a.ce[0]),     32'(n >= 22 && (n - 22) % 3 == 0));
      chk("ce1",    32'(bus_a.ce[1]),     32'(n == 27 || n == 31 || n >= 35));
      chk("ce2",    32'(bus_a.ce[2]),     32'(n >= 283 && (n - 283) % 256 == 0));
      chk("rst_b",  32'(bus_b.rst_out_n), 32'(n >= 4));
      chk("rdy_b",  32'(bus_b.ready),     32'(n >= 4));
      chk("ce_b",   32'(bus_b.ce),        32'(n >= 5));
      if (n == 32) bus_a.div[15:8] = 8'd0;
    end

    // Asynchronous reset in RUN, between edges
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_a_async", 32'(bus_a.rst_out_n), 32'd0);
    chk("rdy_a_async", 32'(bus_a.ready),     32'd0);
    chk("ce_a_async",  32'(bus_a.ce),        32'd0);
    chk("rst_b_async", 32'(bus_b.rst_out_n), 32'd0);
    chk("ce_b_async",  32'(bus_b.ce),        32'd0);

    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      chk("rst_a_r", 32'(bus_a.rst_out_n), 32'({n >= 27, n >= 23, n >= 19}));
      chk("rdy_a_r", 32'(bus_a.ready),     32'(n >= 27));
      chk("ce0_r",   32'(bus_a.ce[0]),     32'(n >= 22 && (n - 22) % 3 == 0));
      chk("ce1_r",   32'(bus_a.ce[1]),     32'(n >= 24));
      chk("rst_b_r", 32'(bus_b.rst_out_n), 32'(n >= 4));
      chk("ce_b_r",  32'(bus_b.ce),        32'(n >= 5));
    end

    // Lock low for edges 25 and 26, during channel release
    restart();
    for (int n = 1; n <= 56; n++) begin
      step();
      chk("rst_a_g", 32'(bus_a.rst_out_n),
          32'({(n >= 53),
               (n >= 23 && n <= 26) || n >= 49,
               (n >= 19 && n <= 26) || n >= 45}));
      chk("rdy_a_g", 32'(bus_a.ready),  32'(n >= 53));
      chk("ce0_g",   32'(bus_a.ce[0]),
          32'((n >= 22 && n <= 26 && (n - 22) % 3 == 0) || (n >= 48 && (n - 48) % 3 == 0)));
      chk("ce1_g",   32'(bus_a.ce[1]),  32'((n >= 24 && n <= 26) || n >= 50));
      chk("ce2_g",   32'(bus_a.ce[2]),  32'd0);
      chk("rst_b_g", 32'(bus_b.rst_out_n), 32'((n >= 4 && n <= 26) || n >= 30));
      chk("ce_b_g",  32'(bus_b.ce),        32'((n >= 5 && n <= 26) || n >= 31));
      if (n == 24) bus_a.lock = 1'b0;
      if (n == 26) bus_a.lock = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
